// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: ALU command codes, shift types, SR bit positions and a rotate helper
package exe_stage_pkg;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction
endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: decode/execute register inputs and execute/memory register outputs
interface exe_stage_if;
  logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN;
  logic [3:0]  EXE_CMD_IN, Dest_IN;
  logic [31:0] PC_in, Val_Rn_IN, Val_Rm_IN;
  logic [11:0] Shift_operand_IN;
  logic [23:0] Signed_imm_24_IN;
  logic [3:0]  SR, Dest;
  logic        Branch_taken, WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0] Branch_Address, ALU_Res, Val_Rm;
  modport master (
    output WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN, EXE_CMD_IN, Dest_IN,
           PC_in, Val_Rn_IN, Val_Rm_IN, Shift_operand_IN, Signed_imm_24_IN,
    input  SR, Dest, Branch_taken, WB_EN, MEM_R_EN, MEM_W_EN, Branch_Address, ALU_Res, Val_Rm
  );
  modport slave (
    input  WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN, EXE_CMD_IN, Dest_IN,
           PC_in, Val_Rn_IN, Val_Rm_IN, Shift_operand_IN, Signed_imm_24_IN,
    output SR, Dest, Branch_taken, WB_EN, MEM_R_EN, MEM_W_EN, Branch_Address, ALU_Res, Val_Rm
  );
endinterface

// File: rtl/exe_stage_val2_gen.sv
// val2_gen: second-operand generator (rotated immediate, memory offset, or shifted Rm)
module val2_gen
  import exe_stage_pkg::*;
(
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_en,
  output logic [31:0] val2
);
  logic [4:0]  amt;
  logic [1:0]  typ;
  logic [31:0] asr, sh;
  always_comb begin
    amt = shift_operand[11:7];
    typ = shift_operand[6:5];
    asr = $signed(val_rm) >>> amt;
    sh = typ == SH_LSL ? val_rm << amt :
         typ == SH_LSR ? val_rm >> amt :
         typ == SH_ASR ? asr : ror32(val_rm, amt);
    val2 = imm    ? ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0}) :
           mem_en ? {{20{shift_operand[11]}}, shift_operand} : sh;
  end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: Val2 + ALU + status register + branch target + execute/memory register
module exe_stage
  import exe_stage_pkg::*;
(
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave e
);
  logic [31:0] val2, b_op, res;
  logic [32:0] sum;
  logic [3:0]  sr, cmd, flags;
  logic        arith, sub, cin, valid;
  val2_gen u_val2 (
    .val_rm        (e.Val_Rm_IN),
    .shift_operand (e.Shift_operand_IN),
    .imm           (e.imm_IN),
    .mem_en        (e.MEM_R_EN_IN | e.MEM_W_EN_IN),
    .val2          (val2)
  );
  // Subtraction is Rn + ~Val2 + cin, so C comes out as NOT borrow directly
  always_comb begin
    cmd = e.EXE_CMD_IN;
    sub = cmd == CMD_SUB || cmd == CMD_SBC;
    arith = sub || cmd == CMD_ADD || cmd == CMD_ADC;
    cin = cmd == CMD_ADD ? 1'b0 : cmd == CMD_SUB ? 1'b1 : sr[SR_C];
    b_op = sub ? ~val2 : val2;
    sum = {1'b0, e.Val_Rn_IN} + {1'b0, b_op} + {32'b0, cin};
    res = arith          ? sum[31:0] :
          cmd == CMD_MOV ? val2 :
          cmd == CMD_MVN ? ~val2 :
          cmd == CMD_AND ? e.Val_Rn_IN & val2 :
          cmd == CMD_ORR ? e.Val_Rn_IN | val2 :
          cmd == CMD_EOR ? e.Val_Rn_IN ^ val2 : 32'b0;
    valid = arith || cmd == CMD_MOV || cmd == CMD_MVN || cmd == CMD_AND ||
            cmd == CMD_ORR || cmd == CMD_EOR;
    flags = {res[31], res == 32'b0,
             arith ? sum[32] : sr[SR_C],
             arith ? (e.Val_Rn_IN[31] == b_op[31]) && (sum[31] != e.Val_Rn_IN[31]) : sr[SR_V]};
  end
  assign e.SR = sr;
  assign e.Branch_taken = e.B_IN;
  assign e.Branch_Address = e.PC_in + {{6{e.Signed_imm_24_IN[23]}}, e.Signed_imm_24_IN, 2'b00};
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= 4'b0;
      e.WB_EN <= 1'b0;
      e.MEM_R_EN <= 1'b0;
      e.MEM_W_EN <= 1'b0;
      e.ALU_Res <= 32'b0;
      e.Val_Rm <= 32'b0;
      e.Dest <= 4'b0;
    end else begin
      if (e.S_IN && valid) sr <= flags;
      e.WB_EN <= e.WB_EN_IN;
      e.MEM_R_EN <= e.MEM_R_EN_IN;
      e.MEM_W_EN <= e.MEM_W_EN_IN;
      e.ALU_Res <= res;
      e.Val_Rm <= e.Val_Rm_IN;
      e.Dest <= e.Dest_IN;
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vectors checked every cycle against a behavioural model
module tb_exe_stage;
  import exe_stage_pkg::*;
  logic clk = 1'b0;
  logic rst;
  exe_stage_if e();
  exe_stage dut (.clk(clk), .rst(rst), .e(e));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;
  logic [3:0]  m_sr = 4'b0, exp_dest;
  logic [31:0] exp_res, exp_rm;
  logic [2:0]  exp_ctrl;
  bit          m_go = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] m_val2(input logic im, input logic mem, input logic [31:0] rm,
                                         input logic [11:0] so);
    logic [31:0] x;
    if (im) begin
      x = {24'b0, so[7:0]};
      for (int i = 0; i < 2 * int'(so[11:8]); i++) x = {x[0], x[31:1]};
    end else if (mem) begin
      x = {{20{so[11]}}, so};
    end else begin
      x = rm;
      for (int i = 0; i < int'(so[11:7]); i++)
        case (so[6:5])
          2'b00:   x = {x[30:0], 1'b0};
          2'b01:   x = {1'b0, x[31:1]};
          2'b10:   x = {x[31], x[31:1]};
          default: x = {x[0], x[31:1]};
        endcase
    end
    return x;
  endfunction
  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                                input logic [3:0] sr_in, output logic [31:0] res, output logic [3:0] sr_out);
    longint ua, ub, sa, sb, s, cb;
    logic c, v, ok;
    ua = longint'({32'b0, rn});
    ub = longint'({32'b0, v2});
    sa = longint'($signed(rn));
    sb = longint'($signed(v2));
    cb = longint'(sr_in[1]);
    c = sr_in[1];
    v = sr_in[0];
    ok = 1'b1;
    s = 0;
    case (cmd)
      4'b0010: begin s = sa + sb;          c = (ua + ub) > 64'hFFFFFFFF;      end
      4'b0011: begin s = sa + sb + cb;     c = (ua + ub + cb) > 64'hFFFFFFFF; end
      4'b0100: begin s = sa - sb;          c = ua >= ub;                       end
      4'b0101: begin s = sa - sb - 1 + cb; c = ua >= ub + 1 - cb;              end
      4'b0001: s = longint'(v2);
      4'b1001: s = longint'(~v2);
      4'b0110: s = longint'(rn & v2);
      4'b0111: s = longint'(rn | v2);
      4'b1000: s = longint'(rn ^ v2);
      default: ok = 1'b0;
    endcase
    if (cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101}) v = (s > MAXI) || (s < MINI);
    res = ok ? s[31:0] : 32'b0;
    sr_out = ok ? {res[31], res == 32'b0, c, v} : sr_in;
  endfunction
  function automatic logic [31:0] m_baddr(input logic [31:0] pc, input logic [23:0] simm);
    longint t;
    t = longint'({32'b0, pc}) + longint'($signed(simm)) * 4;
    return t[31:0];
  endfunction
  always @(posedge clk) begin
    logic [31:0] r;
    logic [3:0]  f;
    if (rst) begin
      m_sr = 4'b0; exp_res = 32'b0; exp_rm = 32'b0; exp_dest = 4'b0; exp_ctrl = 3'b0;
    end else begin
      m_alu(e.EXE_CMD_IN, e.Val_Rn_IN,
            m_val2(e.imm_IN, e.MEM_R_EN_IN | e.MEM_W_EN_IN, e.Val_Rm_IN, e.Shift_operand_IN),
            m_sr, r, f);
      if (e.S_IN) m_sr = f;
      exp_res = r; exp_rm = e.Val_Rm_IN; exp_dest = e.Dest_IN;
      exp_ctrl = {e.WB_EN_IN, e.MEM_R_EN_IN, e.MEM_W_EN_IN};
    end
    m_go = 1'b1;
  end
  always @(negedge clk) if (m_go) begin
    chk("SR", {28'b0, e.SR}, {28'b0, m_sr});
    chk("ALU_Res", e.ALU_Res, exp_res);
    chk("Val_Rm", e.Val_Rm, exp_rm);
    chk("Dest", {28'b0, e.Dest}, {28'b0, exp_dest});
    chk("ctrl", {29'b0, e.WB_EN, e.MEM_R_EN, e.MEM_W_EN}, {29'b0, exp_ctrl});
  end
  task automatic apply(input logic r, input logic wb, input logic mr, input logic mw, input logic b,
                       input logic s, input logic [3:0] cmd, input logic [31:0] pc, input logic [31:0] rn,
                       input logic [31:0] rm, input logic im, input logic [11:0] so,
                       input logic [23:0] simm, input logic [3:0] d);
    @(negedge clk);
    rst = r; e.WB_EN_IN = wb; e.MEM_R_EN_IN = mr; e.MEM_W_EN_IN = mw; e.B_IN = b; e.S_IN = s;
    e.EXE_CMD_IN = cmd; e.PC_in = pc; e.Val_Rn_IN = rn; e.Val_Rm_IN = rm; e.imm_IN = im;
    e.Shift_operand_IN = so; e.Signed_imm_24_IN = simm; e.Dest_IN = d;
    #1;
    chk("Branch_taken", {31'b0, e.Branch_taken}, {31'b0, b});
    chk("Branch_Address", e.Branch_Address, m_baddr(pc, simm));
  endtask
  task automatic bubble(input logic r);
    apply(r, 0, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0, 12'h0, 24'h0, 4'h0);
  endtask
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask
  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    e.WB_EN_IN = 0; e.MEM_R_EN_IN = 0; e.MEM_W_EN_IN = 0; e.B_IN = 0; e.S_IN = 0; e.imm_IN = 0;
    e.EXE_CMD_IN = 0; e.PC_in = 0; e.Val_Rn_IN = 0; e.Val_Rm_IN = 0;
    e.Shift_operand_IN = 0; e.Signed_imm_24_IN = 0; e.Dest_IN = 0;
    bubble(1);
    after_edge();
    lit("reset SR", {28'b0, e.SR}, 32'h0);
    lit("reset ALU_Res", e.ALU_Res, 32'h0);
    apply(0, 1, 0, 0, 0, 1, CMD_ADD, 32'h4, 32'h7FFFFFFF, 32'h0, 1, 12'h001, 24'h0, 4'h1);
    after_edge();
    lit("add ovf res", e.ALU_Res, 32'h80000000);
    lit("add ovf SR", {28'b0, e.SR}, 32'h9);
    apply(0, 0, 0, 0, 0, 1, CMD_SUB, 32'h8, 32'h5, 32'h5, 0, 12'h000, 24'h0, 4'h0);
    after_edge();
    lit("cmp res", e.ALU_Res, 32'h0);
    lit("cmp SR", {28'b0, e.SR}, 32'h6);
    apply(0, 1, 0, 0, 0, 0, CMD_ADC, 32'hC, 32'h1, 32'h0, 1, 12'h001, 24'h0, 4'h2);
    after_edge();
    lit("adc res", e.ALU_Res, 32'h3);
    apply(0, 1, 0, 0, 0, 0, CMD_MOV, 32'h10, 32'h0, 32'h0, 1, 12'h4FF, 24'h0, 4'h3);
    after_edge();
    lit("mov rot res", e.ALU_Res, 32'hFF000000);
    apply(0, 1, 0, 0, 0, 0, CMD_MOV, 32'h14, 32'h0, 32'h80000000, 0, 12'h0C0, 24'h0, 4'h4);
    after_edge();
    lit("asr res", e.ALU_Res, 32'hC0000000);
    apply(0, 1, 1, 0, 0, 0, CMD_ADD, 32'h18, 32'h100, 32'h0, 0, 12'hFFC, 24'h0, 4'h5);
    after_edge();
    lit("ldr addr", e.ALU_Res, 32'hFC);
    lit("ldr mem_r", {31'b0, e.MEM_R_EN}, 32'h1);
    lit("ldr SR kept", {28'b0, e.SR}, 32'h6);
    apply(0, 0, 0, 0, 1, 0, 4'b0, 32'h20, 32'h0, 32'h0, 0, 12'h0, 24'hFFFFFE, 4'h0);
    lit("br taken", {31'b0, e.Branch_taken}, 32'h1);
    lit("br addr", e.Branch_Address, 32'h18);
    apply(0, 1, 0, 1, 0, 0, CMD_ADD, 32'h24, 32'h200, 32'hDEADBEEF, 0, 12'h008, 24'h7FFFFF, 4'h6);
    apply(0, 1, 0, 0, 0, 1, CMD_SBC, 32'h28, 32'h10, 32'h3, 0, 12'h000, 24'h000001, 4'h7);
    apply(0, 1, 0, 0, 0, 1, CMD_SUB, 32'h2C, 32'h80000000, 32'h1, 0, 12'h000, 24'h800000, 4'h8);
    apply(0, 1, 0, 0, 0, 1, CMD_SBC, 32'h30, 32'h2, 32'h5, 0, 12'h000, 24'h0, 4'h9);
    apply(0, 1, 0, 0, 0, 1, CMD_EOR, 32'h34, 32'hF0F0F0F0, 32'h12345678, 0, 12'h220, 24'h0, 4'hA);
    apply(0, 1, 0, 0, 0, 1, CMD_ORR, 32'h38, 32'h0, 32'h80000001, 0, 12'h1E0, 24'h0, 4'hB);
    apply(0, 1, 0, 0, 0, 1, CMD_AND, 32'h3C, 32'h0F0F0F0F, 32'hF0F0F0F0, 0, 12'h000, 24'h0, 4'hC);
    apply(0, 1, 0, 0, 0, 1, CMD_MVN, 32'h40, 32'h0, 32'h0, 1, 12'h000, 24'h0, 4'hD);
    apply(0, 1, 0, 0, 0, 1, CMD_ADC, 32'h44, 32'hFFFFFFFF, 32'h0, 1, 12'h001, 24'h0, 4'hE);
    apply(0, 1, 0, 0, 0, 1, 4'b1111, 32'h48, 32'h12345678, 32'h9, 1, 12'h0AB, 24'h0, 4'hF);
    apply(0, 0, 0, 0, 1, 1, CMD_ADD, 32'h4C, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 12'h000, 24'h000010, 4'h1);
    apply(0, 1, 0, 0, 0, 0, CMD_MOV, 32'h50, 32'h0, 32'h0000ABCD, 0, 12'h420, 24'h0, 4'h2);
    apply(0, 1, 0, 0, 0, 0, CMD_MOV, 32'h54, 32'h0, 32'hFFFFFFFF, 0, 12'hF80, 24'h0, 4'h3);
    bubble(0);
    after_edge();
    lit("bubble res", e.ALU_Res, 32'h0);
    apply(0, 1, 0, 0, 0, 1, CMD_ADD, 32'h58, 32'hFFFFFFFF, 32'h0, 1, 12'h001, 24'h0, 4'h4);
    after_edge();
    lit("add carry SR", {28'b0, e.SR}, 32'h6);
    apply(1, 1, 0, 0, 0, 1, CMD_ADD, 32'h5C, 32'h7FFFFFFF, 32'h0, 1, 12'h001, 24'h0, 4'h5);
    after_edge();
    lit("rst SR", {28'b0, e.SR}, 32'h0);
    lit("rst res", e.ALU_Res, 32'h0);
    lit("rst dest", {28'b0, e.Dest}, 32'h0);
    apply(0, 1, 0, 0, 0, 1, CMD_ADD, 32'h60, 32'h2, 32'h0, 1, 12'h003, 24'h0, 4'h6);
    after_edge();
    lit("post rst res", e.ALU_Res, 32'h5);
    lit("post rst SR", {28'b0, e.SR}, 32'h0);
    bubble(0);
    bubble(0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM-subset pipeline; consumes the decode/execute pipeline register outputs.
- Builds the second operand (Val2), runs the ALU and holds the status register (SR: N,Z,C,V), which feeds back to decode for condition checks.
- Computes the branch target and the branch-taken/flush signal.
- Registers the result into the execute/memory boundary register.

Parameters:
WIDTH, 32, datapath width (fixed ARM word; other values unsupported)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
WB_EN_IN  in  1  writeback enable from decode/execute register
MEM_R_EN_IN  in  1  load
MEM_W_EN_IN  in  1  store
B_IN  in  1  branch (condition already resolved in decode)
S_IN  in  1  update SR
EXE_CMD_IN  in  4  ALU command
PC_in  in  32  PC+4 of the instruction
Val_Rn_IN  in  32  first operand
Val_Rm_IN  in  32  Rm value / store data
imm_IN  in  1  I bit
Shift_operand_IN  in  12  shifter operand field
Signed_imm_24_IN  in  24  branch offset
Dest_IN  in  4  destination register
SR  out  4  {N,Z,C,V}, registered, to decode
Branch_taken  out  1  combinational = B_IN; flushes fetch and decode registers
Branch_Address  out  32  combinational = PC_in + (sign-extended Signed_imm_24_IN << 2), modulo 2^32
WB_EN, MEM_R_EN, MEM_W_EN  out  1 each  registered controls
ALU_Res  out  32  registered ALU result / memory address
Val_Rm  out  32  registered store data
Dest  out  4  registered destination

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. When rst is high at a rising edge, every registered output becomes 0 (SR=0000, ALU_Res=0, Val_Rm=0, Dest=0, all enables 0). This holds mid-operation too; that cycle's SR update is discarded.
- Latency: inputs to registered outputs take exactly 1 cycle. Branch_taken and Branch_Address have 0 latency.
- Val2 is selected in priority order:
  - imm_IN=1: {24'b0, Shift_operand_IN[7:0]} rotated right by 2*Shift_operand_IN[11:8]. Rotate by 0 passes the byte through.
  - Else, if MEM_R_EN_IN or MEM_W_EN_IN: sign-extended Shift_operand_IN[11:0].
  - Else: Val_Rm_IN shifted by Shift_operand_IN[11:7] using type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes the value unchanged.
- EXE_CMD encoding: 0001 MOV (Val2), 1001 MVN (~Val2), 0010 ADD (Rn+Val2), 0011 ADC (+C), 0100 SUB/CMP (Rn-Val2), 0101 SBC (Rn-Val2-!C), 0110 AND/TST, 0111 ORR, 1000 EOR. Any other code gives result 0 and leaves flags unchanged.
- Flag rules:
  - N = result[31]; Z = (result==0).
  - Add: C = carry out of bit 31. Sub: C = NOT borrow (ARM convention).
  - V = signed overflow of the arithmetic operation.
  - Logical and move operations: C and V keep their current SR value.
- SR is loaded at the edge only when S_IN=1. A flushed (bubble) instruction arrives with all controls 0, so it never changes SR.
- ADC and SBC use the SR carry held before the current edge.
- Simultaneous B_IN and S_IN cannot be issued by decode; if they occur, both actions take effect.
- A bubble (all-zero input) produces an all-zero output register.

Decomposition:
- Shared package holds:
  - EXE_CMD constants.
  - Shift-type constants (LSL/LSR/ASR/ROR).
  - SR bit indices N=3, Z=2, C=1, V=0.
- One sub-module: val2_gen (combinational shifter/rotator).
- ALU, SR and the output register stay in exe_stage.

Test Plan:
1. ADD with S_IN=1, Rn=0x7FFFFFFF, imm_IN=1, Shift_operand=0x001 -> next cycle ALU_Res=0x80000000, SR=1001 (N,V).
2. SUB/CMP with S_IN=1, Rn=5, Rm=5, LSL 0 -> ALU_Res=0, SR=0110 (Z,C); then ADC Rn=1, Val2=1 -> ALU_Res=3.
3. Immediate rotate: imm_IN=1, Shift_operand=0x4FF, MOV -> ALU_Res=0xFF000000. Register ASR: Rm=0x80000000, Shift_operand=0x0C0 (ASR #1) -> 0xC0000000.
4. LDR: MEM_R_EN_IN=1, Rn=0x100, Shift_operand=0xFFC -> ALU_Res=0xFC, MEM_R_EN=1. Setting S_IN=0 on the same instruction -> SR unchanged.
5. Branch: B_IN=1, PC_in=0x20, Signed_imm_24=0xFFFFFE -> same-cycle Branch_taken=1, Branch_Address=0x18.
6. Assert rst for one edge during a stream of S-setting ADDs -> all outputs 0 after that edge; the next instruction is processed normally.
